// File: rtl/demux_lane_ctrl_pkg.sv
// demux_lane_ctrl shared definitions
// COM symbol default, FSM encoding and lane index width
package demux_lane_ctrl_pkg;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam int         LANE_W      = 2;

  typedef enum logic {
    SEARCH  = 1'b0,
    ALIGNED = 1'b1
  } state_t;

endpackage

// File: rtl/idle_timer.sv
// idle_timer: 4-bit idle counter for partial-group flush
// o_tc fires combinationally on the enabled cycle that reaches TIMEOUT
module idle_timer #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [3:0] TC_VAL = 4'(TIMEOUT - 1);

  logic [3:0] r_cnt;

  assign o_tc = i_en && (r_cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/demux_lane_ctrl.sv
// demux_lane_ctrl: COM-aligned 1:4 byte lane sequencer
// Emits full 4-byte groups or idle-timed-out partial groups
module demux_lane_ctrl
  import demux_lane_ctrl_pkg::*;
#(
  parameter logic [7:0]  COM_SYM = COM_SYM_DEF,
  parameter int unsigned TIMEOUT = 4,
  parameter int unsigned ERR_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic       valid_in0,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       group_strobe,
  output logic       aligned,
  output logic       align_err,
  output logic [1:0] lane_sel
);

  localparam logic [2:0] ERR_LIM = 3'(ERR_MAX);

  state_t            r_state, w_state_n;
  logic [LANE_W-1:0] r_sel, w_sel_n;
  logic [2:0]        r_err, w_err_n, w_err_inc;
  logic [2:0][7:0]   r_asm, w_asm_n;
  logic [3:0][7:0]   r_out, w_out_n;
  logic [3:0]        r_vout, w_vout_n;
  logic              r_strobe, w_strobe_n;
  logic              r_aerr, w_aerr_n;

  logic w_com, w_act, w_misal, w_cplt;
  logic w_store, w_idle_en, w_flush;

  assign w_com     = (in0 == COM_SYM);
  assign w_act     = (r_state == ALIGNED) && valid_in0;
  assign w_misal   = w_act && w_com && (r_sel != 2'd0);
  assign w_cplt    = w_act && !w_misal && (r_sel == 2'd3);
  assign w_store   = w_act && !w_misal && (r_sel != 2'd3);
  assign w_idle_en = (r_state == ALIGNED) && !valid_in0
                  && (r_sel != 2'd0);
  assign w_err_inc = r_err + 3'd1;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (!w_idle_en),
    .i_en  (w_idle_en),
    .o_tc  (w_flush)
  );

  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    w_err_n    = r_err;
    w_asm_n    = r_asm;
    w_out_n    = r_out;
    w_vout_n   = r_vout;
    w_strobe_n = 1'b0;
    w_aerr_n   = 1'b0;
    if (r_state == SEARCH) begin
      if (valid_in0 && w_com) begin
        w_asm_n[0] = in0;
        w_sel_n    = 2'd1;
        w_state_n  = ALIGNED;
      end
    end else begin
      unique case (1'b1)
        w_misal: begin
          w_aerr_n = 1'b1;
          if (w_err_inc == ERR_LIM) begin
            w_state_n = SEARCH;
            w_err_n   = '0;
            w_sel_n   = 2'd0;
          end else begin
            w_err_n    = w_err_inc;
            w_asm_n[0] = in0;
            w_sel_n    = 2'd1;
          end
        end
        w_cplt: begin
          w_out_n    = {in0, r_asm[2], r_asm[1], r_asm[0]};
          w_vout_n   = 4'hF;
          w_strobe_n = 1'b1;
          w_sel_n    = 2'd0;
          w_err_n    = '0;
        end
        w_store: begin
          case (r_sel)
            2'd0:    w_asm_n[0] = in0;
            2'd1:    w_asm_n[1] = in0;
            default: w_asm_n[2] = in0;
          endcase
          w_sel_n = r_sel + 2'd1;
        end
        w_flush: begin
          for (int i = 0; i < 3; i++) begin
            if (2'(i) < r_sel) begin
              w_out_n[i]  = r_asm[i];
              w_vout_n[i] = 1'b1;
            end else begin
              w_out_n[i]  = '0;
              w_vout_n[i] = 1'b0;
            end
          end
          w_out_n[3]  = '0;
          w_vout_n[3] = 1'b0;
          w_strobe_n  = 1'b1;
          w_sel_n     = 2'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= SEARCH;
      r_sel    <= '0;
      r_err    <= '0;
      r_asm    <= '0;
      r_out    <= '0;
      r_vout   <= '0;
      r_strobe <= 1'b0;
      r_aerr   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_err    <= w_err_n;
      r_asm    <= w_asm_n;
      r_out    <= w_out_n;
      r_vout   <= w_vout_n;
      r_strobe <= w_strobe_n;
      r_aerr   <= w_aerr_n;
    end
  end

  assign out0         = r_out[0];
  assign out1         = r_out[1];
  assign out2         = r_out[2];
  assign out3         = r_out[3];
  assign valid_out0   = r_vout[0];
  assign valid_out1   = r_vout[1];
  assign valid_out2   = r_vout[2];
  assign valid_out3   = r_vout[3];
  assign group_strobe = r_strobe;
  assign aligned      = (r_state == ALIGNED);
  assign align_err    = r_aerr;
  assign lane_sel     = r_sel;

endmodule

// File: tb/tb_demux_lane_ctrl.sv
// tb_demux_lane_ctrl: directed vectors for the lane sequencer
// Outputs are sampled 1ns after each rising edge
module tb_demux_lane_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0;
  logic       valid_in0;
  logic [7:0] out0, out1, out2, out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       group_strobe, aligned, align_err;
  logic [1:0] lane_sel;

  int n_chk  = 0;
  int n_pass = 0;

  demux_lane_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in0          (in0),
    .valid_in0    (valid_in0),
    .out0         (out0),
    .out1         (out1),
    .out2         (out2),
    .out3         (out3),
    .valid_out0   (valid_out0),
    .valid_out1   (valid_out1),
    .valid_out2   (valid_out2),
    .valid_out3   (valid_out3),
    .group_strobe (group_strobe),
    .aligned      (aligned),
    .align_err    (align_err),
    .lane_sel     (lane_sel)
  );

  always #5 clk = ~clk;

  wire [31:0] w_outs = {out0, out1, out2, out3};
  wire [3:0]  w_vo   = {valid_out0, valid_out1,
                        valid_out2, valid_out3};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in0 = v;
    in0       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_in0 = 1'b0;
    in0       = 8'h00;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    valid_in0 = 1'b0;
    in0       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", w_outs, 32'h0);
    chk("rst_vo", w_vo, 4'b0000);
    chk("rst_stb", group_strobe, 1'b0);
    chk("rst_aln", aligned, 1'b0);
    chk("rst_aerr", align_err, 1'b0);
    chk("rst_sel", lane_sel, 2'd0);
    reset = 1'b1;

    // basic group
    step(1, 8'hBC);
    chk("g1_aln", aligned, 1'b1);
    chk("g1_sel1", lane_sel, 2'd1);
    step(1, 8'h11);
    step(1, 8'h22);
    chk("g1_nostb", group_strobe, 1'b0);
    chk("g1_sel3", lane_sel, 2'd3);
    step(1, 8'h33);
    chk("g1_stb", group_strobe, 1'b1);
    chk("g1_outs", w_outs, 32'hBC112233);
    chk("g1_vo", w_vo, 4'b1111);
    chk("g1_sel0", lane_sel, 2'd0);
    step(0, 8'h00);
    chk("g1_stb_low", group_strobe, 1'b0);
    chk("g1_hold", w_outs, 32'hBC112233);

    // junk dropped before COM
    do_reset();
    step(1, 8'h44);
    step(1, 8'h55);
    chk("s_aln", aligned, 1'b0);
    chk("s_sel", lane_sel, 2'd0);
    step(1, 8'hBC);
    step(1, 8'hA1);
    step(1, 8'hA2);
    step(1, 8'hA3);
    chk("s_stb", group_strobe, 1'b1);
    chk("s_outs", w_outs, 32'hBCA1A2A3);

    // back-to-back group, no bubble
    step(1, 8'hBC);
    chk("bb_stb0", group_strobe, 1'b0);
    step(1, 8'hB1);
    step(1, 8'hB2);
    step(1, 8'hB3);
    chk("bb_stb", group_strobe, 1'b1);
    chk("bb_outs", w_outs, 32'hBCB1B2B3);

    // idle timeout flush
    step(1, 8'hBC);
    step(1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00);
      chk("to_early", group_strobe, 1'b0);
    end
    step(0, 8'h00);
    chk("to_stb", group_strobe, 1'b1);
    chk("to_outs", w_outs, 32'hBC010000);
    chk("to_vo", w_vo, 4'b1100);
    chk("to_sel", lane_sel, 2'd0);
    for (int i = 0; i < 6; i++) step(0, 8'h00);
    chk("to_sel0_idle", group_strobe, 1'b0);
    chk("to_hold", w_vo, 4'b1100);

    // byte wins on the timeout cycle
    step(1, 8'hBC);
    step(1, 8'h01);
    for (int i = 0; i < 3; i++) step(0, 8'h00);
    step(1, 8'h02);
    chk("win_nostb", group_strobe, 1'b0);
    chk("win_sel", lane_sel, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00);
      chk("win_early", group_strobe, 1'b0);
    end
    step(0, 8'h00);
    chk("win_stb", group_strobe, 1'b1);
    chk("win_outs", w_outs, 32'hBC010200);
    chk("win_vo", w_vo, 4'b1110);

    // single misaligned COM
    do_reset();
    step(1, 8'hBC);
    step(1, 8'h01);
    step(1, 8'hBC);
    chk("mis_aerr", align_err, 1'b1);
    chk("mis_stb", group_strobe, 1'b0);
    chk("mis_sel", lane_sel, 2'd1);
    chk("mis_aln", aligned, 1'b1);
    step(1, 8'h02);
    chk("mis_aerr_low", align_err, 1'b0);
    step(1, 8'h03);
    step(1, 8'h04);
    chk("mis_stb2", group_strobe, 1'b1);
    chk("mis_outs", w_outs, 32'hBC020304);

    // three misaligned COMs drop alignment
    do_reset();
    step(1, 8'hBC);
    step(1, 8'hBC);
    step(1, 8'hBC);
    chk("drop_aln2", aligned, 1'b1);
    step(1, 8'hBC);
    chk("drop_aln", aligned, 1'b0);
    chk("drop_aerr", align_err, 1'b1);
    chk("drop_sel", lane_sel, 2'd0);
    step(1, 8'h11);
    step(1, 8'h22);
    chk("drop_junk_aln", aligned, 1'b0);
    chk("drop_junk_sel", lane_sel, 2'd0);
    step(1, 8'hBC);
    chk("drop_realn", aligned, 1'b1);
    step(1, 8'h01);
    step(1, 8'h02);
    step(1, 8'h03);
    chk("drop_grp", w_outs, 32'hBC010203);

    // async reset mid-group
    step(1, 8'hBC);
    step(1, 8'h01);
    step(1, 8'h02);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_outs", w_outs, 32'h0);
    chk("ar_vo", w_vo, 4'b0000);
    chk("ar_sel", lane_sel, 2'd0);
    chk("ar_aln", aligned, 1'b0);
    chk("ar_stb", group_strobe, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 8'h00);
    chk("ar_nostb", group_strobe, 1'b0);
    chk("ar_outs2", w_outs, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
